// File: rtl/fir_coef_loader.sv
// Turns SPI coefficient register writes into single-cycle writes on the FIR coefficient
// RAM port, with tap auto-increment, RAM-read arbitration and sticky error reporting.
module fir_coef_loader #(
  parameter int NUM_FILTERS = 4,
  parameter int FILTER_BITS = 2,
  parameter int TAP_BITS    = 8,
  parameter int COEF_WIDTH  = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_sel_wr_stb,
  input  logic [7:0]                      i_filter_select,
  input  logic [7:0]                      i_taps_per_filter,
  input  logic                            i_coef_wr_stb,
  input  logic [7:0]                      i_coef_lsb,
  input  logic [7:0]                      i_coef_msb,
  input  logic                            i_ram_busy,
  input  logic                            i_err_clr,
  output logic                            o_ram_we,
  output logic [FILTER_BITS+TAP_BITS-1:0] o_ram_addr,
  output logic [COEF_WIDTH-1:0]           o_ram_data,
  output logic [TAP_BITS-1:0]             o_tap_ptr,
  output logic                            o_load_done,
  output logic                            o_sel_err,
  output logic                            o_ovf_err,
  output logic                            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

  localparam logic [7:0] NUM_FILTERS_8 = 8'(NUM_FILTERS);

  state_t                          r_state;
  state_t                          w_state_next;
  logic                            r_ram_we;
  logic [FILTER_BITS+TAP_BITS-1:0] r_hold_addr;
  logic [COEF_WIDTH-1:0]           r_hold_data;
  logic [FILTER_BITS-1:0]          r_filter;
  logic [TAP_BITS-1:0]             r_tap_ptr;
  logic                            r_load_done;
  logic                            r_sel_valid;
  logic                            r_adv_suppress;
  logic                            r_sel_err;
  logic                            r_ovf_err;

  logic                            w_sel_ok;
  logic                            w_sel_apply;
  logic                            w_valid_eff;
  logic [FILTER_BITS-1:0]          w_filter_eff;
  logic [TAP_BITS-1:0]             w_tap_eff;
  logic [TAP_BITS-1:0]             w_last_tap;
  logic                            w_coef_accept;
  logic                            w_coef_drop;

  // A select arriving with a coefficient strobe takes effect first, so the
  // captured address and the validity check both use the new selection.
  assign w_sel_ok      = (i_filter_select < NUM_FILTERS_8);
  assign w_sel_apply   = i_sel_wr_stb & w_sel_ok;
  assign w_valid_eff   = i_sel_wr_stb ? w_sel_ok : r_sel_valid;
  assign w_filter_eff  = w_sel_apply ? i_filter_select[FILTER_BITS-1:0] : r_filter;
  assign w_tap_eff     = w_sel_apply ? '0 : r_tap_ptr;
  assign w_last_tap    = i_taps_per_filter[TAP_BITS-1:0] - TAP_BITS'(1);
  assign w_coef_accept = i_coef_wr_stb & w_valid_eff & (r_state == S_IDLE);
  assign w_coef_drop   = i_coef_wr_stb & w_valid_eff & (r_state != S_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_coef_accept) w_state_next = i_ram_busy ? S_WAIT : S_WRITE;
      S_WAIT:  if (!i_ram_busy) w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_ram_we       <= 1'b0;
      r_hold_addr    <= '0;
      r_hold_data    <= '0;
      r_filter       <= '0;
      r_tap_ptr      <= '0;
      r_load_done    <= 1'b0;
      r_sel_valid    <= 1'b1;
      r_adv_suppress <= 1'b0;
      r_sel_err      <= 1'b0;
      r_ovf_err      <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ram_we <= (w_state_next == S_WRITE);

      if (i_sel_wr_stb) begin
        if (w_sel_ok) begin
          r_filter    <= i_filter_select[FILTER_BITS-1:0];
          r_tap_ptr   <= '0;
          r_load_done <= 1'b0;
          r_sel_valid <= 1'b1;
          // The in-flight write keeps its address but must not advance the new filter's pointer.
          if (r_state != S_IDLE) r_adv_suppress <= 1'b1;
        end else begin
          r_sel_valid <= 1'b0;
        end
      end

      if (r_state == S_WRITE && !r_adv_suppress && !w_sel_apply) begin
        if (r_tap_ptr == w_last_tap) begin
          r_tap_ptr   <= '0;
          r_load_done <= 1'b1;
        end else begin
          r_tap_ptr <= r_tap_ptr + TAP_BITS'(1);
        end
      end

      if (w_coef_accept) begin
        r_hold_addr    <= {w_filter_eff, w_tap_eff};
        r_hold_data    <= {i_coef_msb, i_coef_lsb};
        r_adv_suppress <= 1'b0;
      end

      r_sel_err <= (r_sel_err & ~i_err_clr) | (i_sel_wr_stb & ~w_sel_ok);
      r_ovf_err <= (r_ovf_err & ~i_err_clr) | w_coef_drop;
    end
  end

  assign o_ram_we    = r_ram_we;
  assign o_ram_addr  = r_hold_addr;
  assign o_ram_data  = r_hold_data;
  assign o_tap_ptr   = r_tap_ptr;
  assign o_load_done = r_load_done;
  assign o_sel_err   = r_sel_err;
  assign o_ovf_err   = r_ovf_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed/randomized bench for fir_coef_loader against a tap-counting reference model.
module tb_fir_coef_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel_wr_stb, coef_wr_stb, ram_busy, err_clr;
  logic [7:0]  filter_select, taps_per_filter, coef_lsb, coef_msb;
  logic        ram_we, load_done, sel_err, ovf_err, busy;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic [7:0]  tap_ptr;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int m_filter, m_tap, m_taps;
  bit m_done, m_valid, m_sel_err, m_ovf;

  fir_coef_loader dut (
    .i_clk(clk), .i_rst(rst), .i_sel_wr_stb(sel_wr_stb), .i_filter_select(filter_select),
    .i_taps_per_filter(taps_per_filter), .i_coef_wr_stb(coef_wr_stb), .i_coef_lsb(coef_lsb),
    .i_coef_msb(coef_msb), .i_ram_busy(ram_busy), .i_err_clr(err_clr), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_data(ram_data), .o_tap_ptr(tap_ptr), .o_load_done(load_done),
    .o_sel_err(sel_err), .o_ovf_err(ovf_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_filter = 0; m_tap = 0; m_done = 0; m_valid = 1; m_sel_err = 0; m_ovf = 0;
  endtask

  task automatic model_sel(input logic [7:0] v);
    if (v < 4) begin
      m_filter = int'(v); m_tap = 0; m_done = 0; m_valid = 1;
    end else begin
      m_sel_err = 1; m_valid = 0;
    end
  endtask

  task automatic set_taps(input logic [7:0] t);
    taps_per_filter = t;
    m_taps = (t == 0) ? 256 : int'(t);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_tap"},  32'(tap_ptr),   32'(m_tap));
    check({tag, "_done"}, 32'(load_done), 32'(m_done));
    check({tag, "_serr"}, 32'(sel_err),   32'(m_sel_err));
    check({tag, "_ovf"},  32'(ovf_err),   32'(m_ovf));
  endtask

  task automatic do_sel(input logic [7:0] v);
    model_sel(v);
    sel_wr_stb = 1; filter_select = v;
    next_cycle();
    sel_wr_stb = 0;
    @(negedge clk);
    check_status("sel");
    next_cycle();
  endtask

  // One coefficient write; ram_busy is held for b cycles starting at the strobe.
  task automatic coef_write(input logic [15:0] d, input int b, input bit with_sel, input logic [7:0] sv);
    logic [9:0] exp_addr;
    bit         exp_w;
    if (with_sel) model_sel(sv);
    exp_w    = m_valid;
    exp_addr = 10'(m_filter * 256 + m_tap);
    coef_msb = d[15:8]; coef_lsb = d[7:0];
    coef_wr_stb = 1; ram_busy = (b > 0);
    if (with_sel) begin sel_wr_stb = 1; filter_select = sv; end
    next_cycle();
    coef_wr_stb = 0; sel_wr_stb = 0;
    for (int i = 1; i <= b; i++) begin
      ram_busy = (i < b);
      @(negedge clk);
      check("we_wait", 32'(ram_we), 32'(0));
      check("busy_wait", 32'(busy), 32'(exp_w));
      next_cycle();
    end
    @(negedge clk);
    check("we", 32'(ram_we), 32'(exp_w));
    if (exp_w) begin
      check("addr", 32'(ram_addr), 32'(exp_addr));
      check("data", 32'(ram_data), 32'(d));
      m_tap = m_tap + 1;
      if (m_tap == m_taps) begin m_tap = 0; m_done = 1; end
    end
    next_cycle();
    @(negedge clk);
    check("we_after", 32'(ram_we), 32'(0));
    check("busy_after", 32'(busy), 32'(0));
    check_status("wr");
    next_cycle();
  endtask

  initial begin
    logic [15:0] d1, d2;
    logic [9:0]  a1;
    rst = 1; sel_wr_stb = 0; coef_wr_stb = 0; ram_busy = 0; err_clr = 0;
    filter_select = 0; coef_lsb = 0; coef_msb = 0;
    set_taps(8'd4);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we",   32'(ram_we),   32'(0));
    check("rst_addr", 32'(ram_addr), 32'(0));
    check("rst_data", 32'(ram_data), 32'(0));
    check("rst_busy", 32'(busy),     32'(0));
    check_status("rst");
    next_cycle();
    rst = 0;
    next_cycle();

    // Basic load of filter 2, four taps
    do_sel(8'd2);
    for (int i = 0; i < 4; i++) coef_write(16'h1234 + 16'(i), 0, 0, 8'd0);

    // RAM read contention
    coef_write(16'($urandom), 5, 0, 8'd0);

    // Second strobe during WAIT is dropped and flagged
    d1 = 16'($urandom); d2 = ~d1;
    a1 = 10'(m_filter * 256 + m_tap);
    coef_msb = d1[15:8]; coef_lsb = d1[7:0]; coef_wr_stb = 1; ram_busy = 1;
    next_cycle();
    coef_msb = d2[15:8]; coef_lsb = d2[7:0];
    @(negedge clk);
    check("ovf_busy", 32'(busy), 32'(1));
    check("ovf_we0",  32'(ram_we), 32'(0));
    next_cycle();
    coef_wr_stb = 0; ram_busy = 0;
    @(negedge clk);
    check("ovf_flag", 32'(ovf_err), 32'(1));
    check("ovf_we1",  32'(ram_we), 32'(0));
    next_cycle();
    @(negedge clk);
    check("ovf_we",   32'(ram_we),   32'(1));
    check("ovf_addr", 32'(ram_addr), 32'(a1));
    check("ovf_data", 32'(ram_data), 32'(d1));
    m_ovf = 1;
    m_tap = m_tap + 1;
    if (m_tap == m_taps) begin m_tap = 0; m_done = 1; end
    next_cycle();
    @(negedge clk);
    check("ovf_single", 32'(ram_we), 32'(0));
    check_status("ovf");
    next_cycle();
    err_clr = 1;
    next_cycle();
    err_clr = 0; m_ovf = 0;
    @(negedge clk);
    check_status("clr_ovf");
    next_cycle();

    // Invalid select blocks writes; error event beats a simultaneous clear
    do_sel(8'd5);
    coef_write(16'($urandom), 0, 0, 8'd0);
    coef_write(16'($urandom), 2, 0, 8'd0);
    err_clr = 1; sel_wr_stb = 1; filter_select = 8'd7; model_sel(8'd7);
    next_cycle();
    err_clr = 0; sel_wr_stb = 0;
    @(negedge clk);
    check_status("clr_vs_err");
    next_cycle();
    do_sel(8'd1);
    coef_write(16'($urandom), 0, 0, 8'd0);
    err_clr = 1;
    next_cycle();
    err_clr = 0; m_sel_err = 0;
    @(negedge clk);
    check_status("clr_sel");
    next_cycle();

    // Randomized writes with random RAM contention
    for (int i = 0; i < 20; i++) coef_write(16'($urandom), int'($urandom_range(0, 3)), 0, 8'd0);

    // 256-tap filter, then a simultaneous select + coefficient
    set_taps(8'd0);
    do_sel(8'd3);
    for (int i = 0; i < 256; i++) coef_write(16'($urandom), int'($urandom_range(0, 1)), 0, 8'd0);
    coef_write(16'($urandom), 0, 1, 8'd0);
    coef_write(16'($urandom), 1, 1, 8'd6);

    // Asynchronous reset during the write cycle
    do_sel(8'd2);
    coef_msb = 8'hAB; coef_lsb = 8'hCD; coef_wr_stb = 1; ram_busy = 0;
    next_cycle();
    coef_wr_stb = 0;
    @(negedge clk);
    check("pre_rst_we", 32'(ram_we), 32'(1));
    #1 rst = 1;
    #1;
    check("async_rst_we",   32'(ram_we), 32'(0));
    check("async_rst_busy", 32'(busy),   32'(0));
    model_reset();
    next_cycle();
    rst = 0;
    @(negedge clk);
    check_status("post_rst");
    next_cycle();
    coef_write(16'($urandom), 0, 0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
